// File: rtl/adder_sched_if.sv
// adder_sched_if: requester and response handshake bundle for adder_sched
interface adder_sched_if #(parameter int NIBBLES = 3);
  localparam int W = 4 * NIBBLES;
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_sum;
  logic         rsp_co;
  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
  );
  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_sum, rsp_co
  );
endinterface

// File: rtl/adder_sched.sv
// adder_sched: two-requester round-robin scheduler sharing one 4-bit adder, one nibble per cycle
module adder_sched #(parameter int NIBBLES = 3) (
  input logic clk,
  input logic rst_n,
  adder_sched_if.slave bus
);
  localparam int W = 4 * NIBBLES;
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t       state, state_nxt;
  logic [W-1:0] op_a, op_b, sum, sum_nxt, rsp_sum;
  logic [2:0]   nib_idx;
  logic [4:0]   nib_sum;
  logic         carry, id, last_id, rsp_co, rsp_id;
  logic         grant0, grant1, last_nib;
  // On contention the requester that was not served last wins
  always_comb begin
    grant0 = rst_n && state == IDLE && bus.req0_valid && (!bus.req1_valid || last_id);
    grant1 = rst_n && state == IDLE && bus.req1_valid && (!bus.req0_valid || !last_id);
  end
  assign last_nib = nib_idx == 3'(NIBBLES - 1);
  always_comb begin
    nib_sum = {1'b0, op_a[4*nib_idx +: 4]} + {1'b0, op_b[4*nib_idx +: 4]} + {4'b0, carry};
    sum_nxt = sum;
    sum_nxt[4*nib_idx +: 4] = nib_sum[3:0];
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nxt;
  always_comb begin
    state_nxt = (state == IDLE && (grant0 || grant1)) ? CALC :
                (state == CALC && last_nib)           ? RESP :
                (state == RESP && bus.rsp_ready)      ? IDLE : state;
  end
  always_comb begin
    bus.req0_ready = grant0;
    bus.req1_ready = grant1;
    bus.rsp_valid  = state == RESP;
    bus.rsp_sum    = rsp_sum;
    bus.rsp_co     = rsp_co;
    bus.rsp_id     = rsp_id;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      sum     <= '0;
      nib_idx <= '0;
      carry   <= 1'b0;
      id      <= 1'b0;
      last_id <= 1'b1;
      rsp_sum <= '0;
      rsp_co  <= 1'b0;
      rsp_id  <= 1'b0;
    end else begin
      if (grant0 || grant1) begin
        op_a    <= grant1 ? bus.req1_a : bus.req0_a;
        op_b    <= grant1 ? bus.req1_b : bus.req0_b;
        id      <= grant1;
        nib_idx <= '0;
        carry   <= 1'b0;
        sum     <= '0;
      end
      if (state == CALC) begin
        sum     <= sum_nxt;
        carry   <= nib_sum[4];
        nib_idx <= nib_idx + 3'd1;
        if (last_nib) begin
          rsp_sum <= sum_nxt;
          rsp_co  <= nib_sum[4];
          rsp_id  <= id;
        end
      end
      if (state == RESP && bus.rsp_ready) last_id <= id;
    end
  end
endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: directed and soak checks of adder_sched with NIBBLES=3
module tb_adder_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  adder_sched_if #(.NIBBLES(3)) bus();
  adder_sched #(.NIBBLES(3)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task idle_inputs;
    bus.req0_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a = '0;
    bus.req1_b = '0;
    bus.rsp_ready = 1'b1;
  endtask

  // Ends on the negedge right after reset is released, ready to drive the first cycle
  task do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task wait_rsp(input bit drop, output int n);
    n = 0;
    do begin
      @(negedge clk);
      if (drop) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      #1;
      n++;
    end while (!bus.rsp_valid && n < 20);
  endtask

  task test_reset;
    @(negedge clk);
    idle_inputs;
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
      begin errors++; $display("FAIL reset_ready_first: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
      begin errors++; $display("FAIL reset_ready_held: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_co, bus.rsp_sum} !== 15'h0)
      begin errors++; $display("FAIL reset_rsp: got %h want 0", {bus.rsp_valid, bus.rsp_id, bus.rsp_co, bus.rsp_sum}); end
  endtask

  task test_basic;
    int n;
    do_reset;
    bus.req0_valid = 1'b1;
    bus.req0_a = 12'h123;
    bus.req0_b = 12'h456;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10)
      begin errors++; $display("FAIL basic_ready: got %b want 10", {bus.req0_ready, bus.req1_ready}); end
    wait_rsp(1'b1, n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL basic_latency: got %0d want 4", n); end
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_co, bus.rsp_sum} !== {3'b100, 12'h579})
      begin errors++; $display("FAIL basic_rsp: got v%b id%b co%b sum%h want v1 id0 co0 sum579", bus.rsp_valid, bus.rsp_id, bus.rsp_co, bus.rsp_sum); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_rsp_drop: got %b want 0", bus.rsp_valid); end
  endtask

  task test_carry;
    int n;
    do_reset;
    bus.req1_valid = 1'b1;
    bus.req1_a = 12'h0F0;
    bus.req1_b = 12'h010;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01)
      begin errors++; $display("FAIL carry_ready: got %b want 01", {bus.req0_ready, bus.req1_ready}); end
    wait_rsp(1'b1, n);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_co, bus.rsp_sum} !== {3'b110, 12'h100})
      begin errors++; $display("FAIL carry_ripple: got id%b co%b sum%h want id1 co0 sum100", bus.rsp_id, bus.rsp_co, bus.rsp_sum); end
    @(negedge clk);
    bus.req1_valid = 1'b1;
    bus.req1_a = 12'hFFF;
    bus.req1_b = 12'h001;
    #1;
    checks++;
    if (bus.req1_ready !== 1'b1) begin errors++; $display("FAIL overflow_ready: got %b want 1", bus.req1_ready); end
    wait_rsp(1'b1, n);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_co, bus.rsp_sum} !== {3'b111, 12'h000})
      begin errors++; $display("FAIL overflow: got id%b co%b sum%h want id1 co1 sum000", bus.rsp_id, bus.rsp_co, bus.rsp_sum); end
  endtask

  task test_contention;
    int g0n, g1n, ng, nr;
    logic [3:0] gvec;
    logic [13:0] exp;
    bit both;
    do_reset;
    g0n = 0; g1n = 0; ng = 0; nr = 0; gvec = '0; both = 1'b0;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      if (c > 0) @(negedge clk);
      bus.req0_valid = g0n < 2;
      bus.req0_a = g0n == 0 ? 12'h111 : 12'h333;
      bus.req0_b = g0n == 0 ? 12'h222 : 12'h444;
      bus.req1_valid = g1n < 2;
      bus.req1_a = g1n == 0 ? 12'h0AB : 12'h800;
      bus.req1_b = g1n == 0 ? 12'h0CD : 12'h900;
      #1;
      if (bus.req0_ready && bus.req1_ready) both = 1'b1;
      if (bus.req0_ready) begin if (ng < 4) gvec[ng] = 1'b0; ng++; g0n++; end
      if (bus.req1_ready) begin if (ng < 4) gvec[ng] = 1'b1; ng++; g1n++; end
      if (bus.rsp_valid) begin
        exp = nr == 0 ? {2'b00, 12'h333} : nr == 1 ? {2'b10, 12'h178} :
              nr == 2 ? {2'b00, 12'h777} : {2'b11, 12'h100};
        checks++;
        if ({bus.rsp_id, bus.rsp_co, bus.rsp_sum} !== exp)
          begin errors++; $display("FAIL contention_rsp%0d: got %h want %h", nr, {bus.rsp_id, bus.rsp_co, bus.rsp_sum}, exp); end
        nr++;
      end
    end
    checks++;
    if (nr !== 4) begin errors++; $display("FAIL contention_count: got %0d responses want 4", nr); end
    checks++;
    if (ng !== 4 || gvec !== 4'b1010) begin errors++; $display("FAIL contention_order: got %0d grants order %b want 4 order 1010", ng, gvec); end
    checks++;
    if (both !== 1'b0) begin errors++; $display("FAIL contention_onehot: got both readys high want never"); end
    idle_inputs;
  endtask

  task test_backpressure;
    int n;
    bit bad;
    do_reset;
    bus.req0_valid = 1'b1;
    bus.req0_a = 12'h234;
    bus.req0_b = 12'h111;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b want 1", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1;
    bus.req1_a = 12'h500;
    bus.req1_b = 12'h0FF;
    bus.rsp_ready = 1'b0;
    #1;
    n = 1;
    bad = 1'b0;
    while (!bus.rsp_valid && n < 20) begin
      if (bus.req0_ready || bus.req1_ready) bad = 1'b1;
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (n !== 4 || bad !== 1'b0) begin errors++; $display("FAIL bp_calc: got latency %0d ready_seen %b want 4 0", n, bad); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_co, bus.req0_ready, bus.req1_ready, bus.rsp_sum} !== {5'b10000, 12'h345})
        begin errors++; $display("FAIL bp_hold%0d: got v%b id%b co%b rdy%b%b sum%h want v1 id0 co0 rdy00 sum345", i, bus.rsp_valid, bus.rsp_id, bus.rsp_co, bus.req0_ready, bus.req1_ready, bus.rsp_sum); end
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req1_ready} !== 2'b10)
      begin errors++; $display("FAIL bp_handshake: got v%b rdy1 %b want v1 rdy1 0", bus.rsp_valid, bus.req1_ready); end
    @(negedge clk);
    #1;
    checks++;
    if ({bus.rsp_valid, bus.req1_ready} !== 2'b01)
      begin errors++; $display("FAIL bp_next_accept: got v%b rdy1 %b want v0 rdy1 1", bus.rsp_valid, bus.req1_ready); end
    wait_rsp(1'b1, n);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_co, bus.rsp_sum} !== {3'b110, 12'h5FF})
      begin errors++; $display("FAIL bp_second: got id%b co%b sum%h want id1 co0 sum5ff", bus.rsp_id, bus.rsp_co, bus.rsp_sum); end
  endtask

  task test_reset_mid;
    int nr;
    bit drop1;
    logic [13:0] exp;
    do_reset;
    bus.req0_valid = 1'b1;
    bus.req0_a = 12'h321;
    bus.req0_b = 12'h123;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL mid_accept: got %b want 1", bus.req0_ready); end
    @(negedge clk);
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_a = 12'h010;
    bus.req0_b = 12'h020;
    bus.req1_valid = 1'b1;
    bus.req1_a = 12'h0A0;
    bus.req1_b = 12'h005;
    #1;
    checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00)
      begin errors++; $display("FAIL mid_reset_ready: got %b want 00", {bus.req0_ready, bus.req1_ready}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({bus.rsp_valid, bus.rsp_sum, bus.req0_ready, bus.req1_ready} !== {1'b0, 12'h000, 2'b10})
      begin errors++; $display("FAIL mid_after_reset: got v%b sum%h rdy%b%b want v0 sum000 rdy10", bus.rsp_valid, bus.rsp_sum, bus.req0_ready, bus.req1_ready); end
    nr = 0;
    drop1 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.req0_valid = 1'b0;
      if (drop1) bus.req1_valid = 1'b0;
      #1;
      if (bus.req1_ready) drop1 = 1'b1;
      if (bus.rsp_valid) begin
        exp = nr == 0 ? {2'b00, 12'h030} : {2'b10, 12'h0A5};
        checks++;
        if (nr > 1 || {bus.rsp_id, bus.rsp_co, bus.rsp_sum} !== exp)
          begin errors++; $display("FAIL mid_rsp%0d: got %h want %h", nr, {bus.rsp_id, bus.rsp_co, bus.rsp_sum}, exp); end
        nr++;
      end
    end
    checks++;
    if (nr !== 2) begin errors++; $display("FAIL mid_count: got %0d responses want 2", nr); end
  endtask

  task test_soak;
    logic [13:0] q[$];
    logic [13:0] exp;
    int acc, got, pend;
    bit dr0, dr1, m_last, gid;
    do_reset;
    acc = 0; got = 0; dr0 = 0; dr1 = 0; m_last = 1'b1;
    for (int c = 0; c < 40000 && got < 1000; c++) begin
      if (c > 0) @(negedge clk);
      if (dr0) begin bus.req0_valid = 1'b0; dr0 = 0; end
      if (dr1) begin bus.req1_valid = 1'b0; dr1 = 0; end
      pend = int'(bus.req0_valid) + int'(bus.req1_valid);
      if (!bus.req0_valid && acc + pend < 1000 && $urandom_range(0, 1) == 1) begin
        bus.req0_valid = 1'b1;
        bus.req0_a = 12'($urandom);
        bus.req0_b = 12'($urandom);
        pend++;
      end
      if (!bus.req1_valid && acc + pend < 1000 && $urandom_range(0, 1) == 1) begin
        bus.req1_valid = 1'b1;
        bus.req1_a = 12'($urandom);
        bus.req1_b = 12'($urandom);
      end
      bus.rsp_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus.req0_ready && bus.req1_ready) begin
        checks++; errors++;
        $display("FAIL soak_onehot: got both readys high at cycle %0d want at most one", c);
      end else if (bus.req0_ready || bus.req1_ready) begin
        gid = bus.req1_ready;
        if (bus.req0_valid && bus.req1_valid) begin
          checks++;
          if (gid !== ~m_last) begin errors++; $display("FAIL soak_arb: got grant %b want %b", gid, ~m_last); end
        end
        q.push_back(gid ? {1'b1, {1'b0, bus.req1_a} + {1'b0, bus.req1_b}}
                        : {1'b0, {1'b0, bus.req0_a} + {1'b0, bus.req0_b}});
        acc++;
        if (gid) dr1 = 1; else dr0 = 1;
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        exp = q.size() > 0 ? q.pop_front() : 14'h3FFF;
        checks++;
        if ({bus.rsp_id, bus.rsp_co, bus.rsp_sum} !== exp)
          begin errors++; $display("FAIL soak_rsp%0d: got %h want %h", got, {bus.rsp_id, bus.rsp_co, bus.rsp_sum}, exp); end
        m_last = exp[13];
        got++;
      end
    end
    checks++;
    if (got !== 1000 || q.size() !== 0)
      begin errors++; $display("FAIL soak_done: got %0d responses %0d pending want 1000 0", got, q.size()); end
    idle_inputs;
  endtask

  initial begin
    idle_inputs;
    test_reset;
    test_basic;
    test_carry;
    test_contention;
    test_backpressure;
    test_reset_mid;
    test_soak;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
